// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and defaults for the code lock
package lock_pkg;

  // Two-bit binary encoding; every code point is a real state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_e;

  localparam int          CODE_W_DEF    = 3;
  localparam logic [2:0]  RESET_KEY_DEF = 3'b000;

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by OPEN and LOCKOUT
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/code_lock_controller.sv
// rtl/code_lock_controller.sv - entry/key registers and unlock/lockout sequencer
module code_lock_controller
  import lock_pkg::*;
#(
  parameter int                CODE_W         = CODE_W_DEF,
  parameter logic [CODE_W-1:0] RESET_KEY      = CODE_W'(RESET_KEY_DEF),
  parameter int                MAX_TRIES      = 3,
  parameter int                OPEN_CYCLES    = 8,
  parameter int                LOCKOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              enter,
  input  logic              prog,
  input  logic              match_in,
  output logic [CODE_W-1:0] cmp_entry,
  output logic [CODE_W-1:0] cmp_key,
  output logic              unlock,
  output logic              alarm,
  output logic              busy,
  output logic [2:0]        fail_cnt
);

  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  lock_state_e state, state_nxt;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_dec;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;
  logic          key_wr;
  logic          fail_last;

  // One more failure reaches the lockout threshold.
  assign fail_last = (({1'b0, fail_cnt} + 4'd1) >= 4'(MAX_TRIES));
  assign key_wr    = (state == OPEN) && enter && prog;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Next-state and timer control; match_in is only consulted in CHECK.
  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (enter) state_nxt = CHECK;
      end
      CHECK: begin
        if (match_in) begin
          state_nxt    = OPEN;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(OPEN_CYCLES - 1);
        end else if (!fail_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt    = LOCKOUT;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(LOCKOUT_CYCLES - 1);
        end
      end
      OPEN: begin
        if (key_wr || tmr_zero) state_nxt = IDLE;
        else                    tmr_dec   = 1'b1;
      end
      LOCKOUT: begin
        if (tmr_zero) state_nxt = IDLE;
        else          tmr_dec   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath registers and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmp_entry <= '0;
      cmp_key   <= RESET_KEY;
      fail_cnt  <= 3'd0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      unlock <= (state_nxt == OPEN);
      alarm  <= (state_nxt == LOCKOUT);
      busy   <= (state_nxt == CHECK) || (state_nxt == LOCKOUT);

      if ((state == IDLE) && enter) cmp_entry <= code_in;
      if (key_wr)                   cmp_key   <= code_in;

      if (state == CHECK) begin
        if (match_in)        fail_cnt <= 3'd0;
        else if (!fail_last) fail_cnt <= fail_cnt + 3'd1;
        else                 fail_cnt <= 3'(MAX_TRIES);
      end else if ((state == LOCKOUT) && tmr_zero) begin
        fail_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_code_lock_controller.sv
// tb/tb_code_lock_controller.sv - directed self-checking bench for code_lock_controller
module tb_code_lock_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_in;
  logic       enter;
  logic       prog;
  logic       match_in;
  logic [2:0] cmp_entry;
  logic [2:0] cmp_key;
  logic       unlock;
  logic       alarm;
  logic       busy;
  logic [2:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External 3-bit equality comparator.
  assign match_in = (cmp_entry == cmp_key);

  code_lock_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .enter     (enter),
    .prog      (prog),
    .match_in  (match_in),
    .cmp_entry (cmp_entry),
    .cmp_key   (cmp_key),
    .unlock    (unlock),
    .alarm     (alarm),
    .busy      (busy),
    .fail_cnt  (fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] code, input logic p);
    code_in = code;
    prog    = p;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    prog    = 1'b0;
  endtask

  task automatic wait_unlock_low();
    int k = 0;
    while (unlock && k < 40) begin
      tick();
      k++;
    end
    check("unlock_drop", unlock, 0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; code_in = 3'd0; enter = 1'b0; prog = 1'b0;
    #2;
    check("rst_unlock", unlock, 0);
    check("rst_alarm", alarm, 0);
    check("rst_busy", busy, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_key", cmp_key, 3'b000);
    check("rst_entry", cmp_entry, 3'b000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Correct code unlocks for exactly 8 cycles.
    press(3'b000, 1'b0);
    check("t1_busy_check", busy, 1);
    check("t1_unlock_check", unlock, 0);
    check("t1_entry", cmp_entry, 3'b000);
    tick();
    n = 0;
    while (unlock && n < 40) begin n++; tick(); end
    check("t1_open_len", n, 8);
    check("t1_fail", fail_cnt, 0);
    check("t1_busy_idle", busy, 0);

    // Three wrong codes trigger a 16-cycle lockout; enters inside are ignored.
    press(3'b101, 1'b0); tick();
    check("t2_fail1", fail_cnt, 1);
    check("t2_busy1", busy, 0);
    press(3'b101, 1'b0); tick();
    check("t2_fail2", fail_cnt, 2);
    press(3'b101, 1'b0); tick();
    check("t2_alarm", alarm, 1);
    check("t2_busy_lock", busy, 1);
    check("t2_fail3", fail_cnt, 3);
    n = 0;
    code_in = 3'b000;
    while (alarm && n < 40) begin
      enter = (n == 3) || (n == 5);
      n++;
      tick();
    end
    enter = 1'b0;
    check("t2_lock_len", n, 16);
    check("t2_fail_clr", fail_cnt, 0);
    check("t2_busy_after", busy, 0);
    tick();
    check("t2_no_unlock", unlock, 0);
    check("t2_entry_kept", cmp_entry, 3'b101);

    // Two failures then a match clears the count.
    press(3'b101, 1'b0); tick();
    press(3'b110, 1'b0); tick();
    check("t3_fail2", fail_cnt, 2);
    press(3'b000, 1'b0); tick();
    check("t3_unlock", unlock, 1);
    check("t3_fail_clr", fail_cnt, 0);
    wait_unlock_low();
    press(3'b111, 1'b0); tick();
    check("t3_fail1", fail_cnt, 1);
    check("t3_no_alarm", alarm, 0);

    // Key write in the third OPEN cycle.
    press(3'b000, 1'b0); tick();
    check("t4_unlock", unlock, 1);
    tick(); tick();
    check("t4_still_open", unlock, 1);
    press(3'b110, 1'b1);
    check("t4_key", cmp_key, 3'b110);
    check("t4_idle_unlock", unlock, 0);
    check("t4_idle_busy", busy, 0);
    press(3'b000, 1'b0); tick();
    check("t4_old_key_fail", unlock, 0);
    check("t4_old_key_cnt", fail_cnt, 1);
    press(3'b110, 1'b0); tick();
    check("t4_new_key_unlock", unlock, 1);
    wait_unlock_low();

    // Key write on the timer-expiry cycle.
    press(3'b110, 1'b0); tick();
    for (int i = 0; i < 7; i++) tick();
    check("t5_last_open", unlock, 1);
    press(3'b011, 1'b1);
    check("t5_key_expiry", cmp_key, 3'b011);
    check("t5_unlock_off", unlock, 0);

    // Enter without prog in OPEN does not extend unlock.
    press(3'b011, 1'b0); tick();
    n = 0;
    code_in = 3'b011;
    while (unlock && n < 40) begin
      enter = (n == 2);
      n++;
      tick();
    end
    enter = 1'b0;
    check("t5_open_len", n, 8);
    check("t5_key_kept", cmp_key, 3'b011);

    // Async reset during lockout.
    press(3'b101, 1'b0); tick();
    press(3'b101, 1'b0); tick();
    press(3'b101, 1'b0); tick();
    check("t6_alarm", alarm, 1);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_alarm_rst", alarm, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_fail_rst", fail_cnt, 0);
    check("t6_key_rst", cmp_key, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();
    press(3'b000, 1'b0); tick();
    check("t6_unlock_reset_key", unlock, 1);
    wait_unlock_low();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/code_lock_controller.md
Name: code_lock_controller

Overview:
- Sequential controller for the 3-bit code-lock datapath.
- Registers the user-entered code and the stored key, and drives both to the external 3-bit equality comparator (inputs A..C = entry, D..F = key).
- Consumes the comparator's match output FI and runs the unlock, fail-count, lockout and key-reprogramming sequence.

Parameters:
- CODE_W, 3, width of entered code and stored key (must equal comparator width).
- RESET_KEY, 3'b000, key value loaded on reset.
- MAX_TRIES, 3, consecutive failed checks that trigger lockout (1..7).
- OPEN_CYCLES, 8, cycles unlock stays asserted after a match (>=1).
- LOCKOUT_CYCLES, 16, cycles alarm stays asserted during lockout (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- code_in  in  CODE_W  code presented by keypad.
- enter  in  1  single-cycle strobe: submit code_in.
- prog  in  1  level: when high with enter while OPEN, code_in becomes the new key.
- match_in  in  1  comparator FI; combinational function of cmp_entry/cmp_key.
- cmp_entry  out  CODE_W  registered entry to comparator A,B,C.
- cmp_key  out  CODE_W  registered key to comparator D,E,F.
- unlock  out  1  high in OPEN.
- alarm  out  1  high in LOCKOUT.
- busy  out  1  high in CHECK or LOCKOUT (enter ignored).
- fail_cnt  out  3  current consecutive failure count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, entry_q=0, key_q=RESET_KEY, fail_cnt=0, timer=0.
  - unlock=0, alarm=0, busy=0.
  - Deassertion takes effect at the next rising edge. Reset mid-OPEN or mid-LOCKOUT aborts immediately and restores RESET_KEY.
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- Comparator timing: match_in is sampled in CHECK, one cycle after entry_q loads, so the combinational comparator has a full cycle.
- IDLE:
  - enter=1: entry_q<=code_in, go to CHECK. prog is ignored in IDLE.
- CHECK (exactly 1 cycle, busy=1):
  - match_in=1: fail_cnt<=0, timer<=OPEN_CYCLES-1, go to OPEN.
  - match_in=0 and fail_cnt+1<MAX_TRIES: fail_cnt<=fail_cnt+1, go to IDLE.
  - match_in=0 and fail_cnt+1==MAX_TRIES: fail_cnt<=MAX_TRIES, timer<=LOCKOUT_CYCLES-1, go to LOCKOUT.
  - enter during CHECK is dropped.
- OPEN (unlock=1):
  - Each cycle: timer==0 -> IDLE, else timer decrements.
  - enter=1 and prog=1: key_q<=code_in, go to IDLE next cycle. This has priority over timer expiry in the same cycle.
  - enter=1 and prog=0: ignored, timer not restarted.
- LOCKOUT (alarm=1, busy=1):
  - enter and prog ignored. timer counts down.
  - At timer==0: fail_cnt<=0, go to IDLE.
- Latency:
  - enter to unlock = 2 edges (IDLE->CHECK->OPEN).
  - unlock lasts exactly OPEN_CYCLES cycles unless cut short by a key write.
  - alarm lasts exactly LOCKOUT_CYCLES cycles.
- A successful match clears fail_cnt at any count below MAX_TRIES. Failures are counted only in CHECK.
- cmp_entry holds its last entered value between entries. cmp_key changes only on a key write or reset.
- Timer width is clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)). fail_cnt saturates at MAX_TRIES and never wraps.
- State encoding is binary (3 states would fit 2 bits; 4 states use 2 bits). There are no illegal-state hazards; unused encodings return to IDLE.

Decomposition:
- Shared package lock_pkg holds:
  - state enum {IDLE, CHECK, OPEN, LOCKOUT}.
  - CODE_W default and RESET_KEY default constants.
- One natural sub-module, lock_timer: loadable down-counter with load/value/zero flag, reused for both OPEN and LOCKOUT durations.
- The comparator stays external and is instantiated beside this block at the top level. It is not instantiated inside this block.

Test Plan:
- Reset, then enter code_in=3'b000 with the bench comparator model: CHECK next cycle, unlock=1 for exactly 8 cycles, fail_cnt=0.
- Enter 3'b101 three times (key 000): fail_cnt goes 1, 2, then alarm=1 for 16 cycles with busy=1. Enters during alarm are ignored. Then IDLE with fail_cnt=0.
- Two wrong codes (fail_cnt=2), then correct 000: unlock=1 and fail_cnt=0. A later wrong code gives fail_cnt=1, not lockout.
- Unlock with 000, then in cycle 3 of OPEN assert prog=1, enter=1, code_in=3'b110: cmp_key=110, IDLE next cycle. Entering 000 then fails; entering 110 unlocks.
- Key write on the same cycle as OPEN timer expiry: key updates to code_in. Also: enter with prog=0 in OPEN does not extend unlock beyond 8 cycles.
- Assert rst_n=0 asynchronously mid-LOCKOUT (no clock edge): alarm=0, busy=0 and fail_cnt=0 immediately, and cmp_key returns to 000.
